// File: rtl/btn_ctrl_pkg.sv
// Shared types and helpers for the button gesture controller.
package btn_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRESS1,
    GAP,
    PRESS2,
    HOLD
  } state_e;

  typedef struct packed {
    logic short_ev;
    logic long_ev;
    logic double_ev;
    logic repeat_ev;
  } evt_t;

  function automatic int unsigned cycles_per_ms(input int unsigned clk_freq);
    return clk_freq / 1000;
  endfunction

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/ms_timer.sv
// Millisecond prescaler plus a saturating millisecond counter; clear_i restarts both.
module ms_timer
  import btn_ctrl_pkg::*;
#(
  parameter int unsigned ClkFreq = 100_000_000,
  parameter int unsigned MaxMs   = 1000
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     clear_i,
  output logic                     ms_tick_o,
  output logic [$clog2(MaxMs):0]   ms_cnt_o
);

  localparam int unsigned CycPerMs = cycles_per_ms(ClkFreq);
  localparam int unsigned PreW     = $clog2(CycPerMs) + 1;
  localparam int unsigned CntW     = $clog2(MaxMs) + 1;
  localparam logic [PreW-1:0] PreLast = PreW'(CycPerMs - 1);
  localparam logic [CntW-1:0] CntMax  = CntW'(MaxMs);

  logic [PreW-1:0] r_pre;
  logic [CntW-1:0] r_cnt;
  logic            w_wrap;

  assign w_wrap = (r_pre == PreLast);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_pre <= '0;
      r_cnt <= '0;
    end else if (clear_i) begin
      r_pre <= '0;
      r_cnt <= '0;
    end else begin
      r_pre <= w_wrap ? '0 : r_pre + 1'b1;
      if (w_wrap && (r_cnt != CntMax)) r_cnt <= r_cnt + 1'b1;
    end
  end

  assign ms_tick_o = w_wrap;
  assign ms_cnt_o  = r_cnt;

endmodule

// File: rtl/btn_gesture_ctrl.sv
// Classifies debounced presses as short / long / double-click and emits one-cycle pulses.
// Optional auto-repeat while held is enabled by defining BTN_REPEAT_EN.
module btn_gesture_ctrl
  import btn_ctrl_pkg::*;
#(
  parameter int unsigned ClkFreq     = 100_000_000,
  parameter int unsigned LongPressMs = 1000,
  parameter int unsigned DoubleGapMs = 250,
  parameter int unsigned RepeatMs    = 100
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic enable_i,
  input  logic db_level_i,
  input  logic db_tick_i,
  output logic short_o,
  output logic long_o,
  output logic double_o,
  output logic repeat_o,
  output logic busy_o
);

  localparam int unsigned MaxMs = max3(LongPressMs, DoubleGapMs, RepeatMs);
  localparam int unsigned CntW  = $clog2(MaxMs) + 1;
  localparam logic [CntW-1:0] LongCnt = CntW'(LongPressMs);
  localparam logic [CntW-1:0] GapCnt  = CntW'(DoubleGapMs);
`ifdef BTN_REPEAT_EN
  localparam logic [CntW-1:0] RepLast = CntW'(RepeatMs - 1);
`endif

  state_e          r_state, w_state_nxt;
  evt_t            r_evt, w_evt;
  logic            r_level;
  logic            w_fall, w_clear, w_rep_clr;
  logic            w_ms_tick;
  logic [CntW-1:0] w_ms_cnt;

  assign w_fall = r_level && !db_level_i;

  ms_timer #(
    .ClkFreq (ClkFreq),
    .MaxMs   (MaxMs)
  ) u_timer (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .clear_i   (w_clear),
    .ms_tick_o (w_ms_tick),
    .ms_cnt_o  (w_ms_cnt)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_evt       = '0;
    w_rep_clr   = 1'b0;
    case (r_state)
      IDLE:   if (db_tick_i) w_state_nxt = PRESS1;
      PRESS1: begin
        if (w_fall) begin
          w_state_nxt = GAP;
        end else if (w_ms_cnt == LongCnt) begin
          w_state_nxt   = HOLD;
          w_evt.long_ev = 1'b1;
        end
      end
      GAP: begin
        if (db_tick_i) begin
          w_state_nxt = PRESS2;
        end else if (w_ms_cnt == GapCnt) begin
          w_state_nxt    = IDLE;
          w_evt.short_ev = 1'b1;
        end
      end
      PRESS2: begin
        if (w_fall) begin
          w_state_nxt     = IDLE;
          w_evt.double_ev = 1'b1;
        end
      end
      HOLD: begin
        if (w_fall) begin
          w_state_nxt = IDLE;
        end
`ifdef BTN_REPEAT_EN
        // Restart on the tick that would make the count reach RepeatMs, so the
        // period is exactly RepeatMs and not RepeatMs plus one cycle.
        else if (w_ms_tick && (w_ms_cnt == RepLast)) begin
          w_evt.repeat_ev = 1'b1;
          w_rep_clr       = 1'b1;
        end
`endif
      end
      default: w_state_nxt = IDLE;
    endcase
    if (!enable_i) begin
      w_state_nxt = IDLE;
      w_evt       = '0;
      w_rep_clr   = 1'b0;
    end
  end

`ifndef BTN_REPEAT_EN
  logic w_unused_tick;
  assign w_unused_tick = w_ms_tick;
`endif

  assign w_clear = (w_state_nxt != r_state) || w_rep_clr || !enable_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
      r_evt   <= '0;
      r_level <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_evt   <= w_evt;
      r_level <= db_level_i;
    end
  end

  assign short_o  = r_evt.short_ev;
  assign long_o   = r_evt.long_ev;
  assign double_o = r_evt.double_ev;
  assign repeat_o = r_evt.repeat_ev;
  assign busy_o   = (r_state != IDLE);

endmodule

// File: tb/tb_btn_gesture_ctrl.sv
// Directed bench for btn_gesture_ctrl at 10 clocks per ms (Long=20, Gap=5, Repeat=10 ms).
module tb_btn_gesture_ctrl;

  logic clk = 1'b0;
  logic rst_n, en, lvl, tick;
  logic s_o, l_o, d_o, r_o, busy;

  int cyc = 0;
  int n_short, n_long, n_double, n_repeat, n_multi;
  int t_short, t_long, t_double, t_rep_first, t_rep_last;
  int n_checks = 0;
  int n_pass   = 0;
  int t_tick, t_fall, t_fall2, t_dummy;

  btn_gesture_ctrl #(
    .ClkFreq     (10_000),
    .LongPressMs (20),
    .DoubleGapMs (5),
    .RepeatMs    (10)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .enable_i   (en),
    .db_level_i (lvl),
    .db_tick_i  (tick),
    .short_o    (s_o),
    .long_o     (l_o),
    .double_o   (d_o),
    .repeat_o   (r_o),
    .busy_o     (busy)
  );

  always #5 clk = ~clk;

  // cyc == k between posedge k and posedge k+1; pulses are stamped with the
  // index of the posedge that registered them.
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (s_o) begin n_short++;  t_short  = cyc; end
    if (l_o) begin n_long++;   t_long   = cyc; end
    if (d_o) begin n_double++; t_double = cyc; end
    if (r_o) begin
      n_repeat++;
      if (n_repeat == 1) t_rep_first = cyc;
      t_rep_last = cyc;
    end
    if ($countones({s_o, l_o, d_o, r_o}) > 1) n_multi++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_counts();
    n_short = 0; n_long = 0; n_double = 0; n_repeat = 0;
    t_short = 0; t_long = 0; t_double = 0; t_rep_first = 0; t_rep_last = 0;
  endtask

  // Present a rising edge so that it is sampled by posedge 'at' (or the next one).
  task automatic press_at(input int at, output int t);
    @(negedge clk);
    while (cyc + 1 < at) @(negedge clk);
    lvl = 1'b1; tick = 1'b1; t = cyc + 1;
    @(negedge clk);
    tick = 1'b0;
  endtask

  task automatic release_at(input int at, output int t);
    @(negedge clk);
    while (cyc + 1 < at) @(negedge clk);
    lvl = 1'b0; t = cyc + 1;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; lvl = 1'b0; tick = 1'b0;
    clear_counts();
    n_multi = 0;
    idle(3);
    check("rst_outputs", {28'd0, s_o, l_o, d_o, r_o}, 32'd0);
    check("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    idle(3);

    // Short press: 8 ms hold, short_o 51 cycles after the fall.
    clear_counts();
    press_at(0, t_tick);
    idle(3);
    check("t1_busy_press", busy, 1'b1);
    release_at(t_tick + 80, t_fall);
    idle(100);
    check("t1_short_cnt", n_short, 1);
    check("t1_short_dly", t_short - t_fall, 51);
    check("t1_long_cnt", n_long, 0);
    check("t1_double_cnt", n_double, 0);
    check("t1_busy_end", busy, 1'b0);

    // Long press with a stray tick during PRESS1; no event on release.
    clear_counts();
    press_at(0, t_tick);
    idle(100);
    @(negedge clk); tick = 1'b1;
    @(negedge clk); tick = 1'b0;
    release_at(t_tick + 250, t_fall);
    idle(300);
    check("t2_long_cnt", n_long, 1);
    check("t2_long_dly", t_long - t_tick, 201);
    check("t2_short_cnt", n_short, 0);
    check("t2_double_cnt", n_double, 0);
    check("t2_repeat_cnt", n_repeat, 0);
    check("t2_busy_end", busy, 1'b0);

    // Double click: 3 ms, 2 ms gap, 3 ms.
    clear_counts();
    press_at(0, t_tick);
    release_at(t_tick + 30, t_fall);
    press_at(t_fall + 20, t_tick);
    release_at(t_tick + 30, t_fall2);
    idle(100);
    check("t3_double_cnt", n_double, 1);
    check("t3_double_dly", t_double - t_fall2, 0);
    check("t3_short_cnt", n_short, 0);
    check("t3_long_cnt", n_long, 0);

    // Reset during GAP aborts the gesture immediately.
    clear_counts();
    press_at(0, t_tick);
    release_at(t_tick + 30, t_fall);
    idle(20);
    @(negedge clk); rst_n = 1'b0;
    #1;
    check("t4_rst_busy", busy, 1'b0);
    check("t4_rst_outputs", {28'd0, s_o, l_o, d_o, r_o}, 32'd0);
    @(negedge clk);
    @(negedge clk); rst_n = 1'b1;
    idle(100);
    check("t4_short_cnt", n_short, 0);
    check("t4_busy_end", busy, 1'b0);

    // One-cycle enable drop during GAP.
    clear_counts();
    press_at(0, t_tick);
    release_at(t_tick + 30, t_fall);
    idle(20);
    check("t5_busy_gap", busy, 1'b1);
    @(negedge clk); en = 1'b0;
    @(negedge clk); en = 1'b1;
    check("t5_busy_after", busy, 1'b0);
    idle(100);
    check("t5_short_cnt", n_short, 0);

    // Fall in the same cycle the count reaches LongPressMs: fall wins.
    clear_counts();
    press_at(0, t_tick);
    release_at(t_tick + 201, t_fall);
    idle(100);
    check("t6_long_cnt", n_long, 0);
    check("t6_short_cnt", n_short, 1);
    check("t6_short_dly", t_short - t_fall, 51);

    // Re-press in the same cycle the gap times out: tick wins.
    clear_counts();
    press_at(0, t_tick);
    release_at(t_tick + 30, t_fall);
    press_at(t_fall + 51, t_tick);
    release_at(t_tick + 30, t_fall2);
    idle(100);
    check("t7_short_cnt", n_short, 0);
    check("t7_double_cnt", n_double, 1);
    check("t7_double_dly", t_double - t_fall2, 0);

    // 45 ms hold: long at 20 ms, repeats at 30/40 ms only when enabled.
    clear_counts();
    press_at(0, t_tick);
    release_at(t_tick + 450, t_fall);
    idle(300);
    check("t8_long_cnt", n_long, 1);
    check("t8_long_dly", t_long - t_tick, 201);
    check("t8_short_cnt", n_short, 0);
`ifdef BTN_REPEAT_EN
    check("t8_repeat_cnt", n_repeat, 2);
    check("t8_repeat1_dly", t_rep_first - t_tick, 301);
    check("t8_repeat2_dly", t_rep_last - t_tick, 401);
`else
    check("t8_repeat_cnt", n_repeat, 0);
`endif
    check("t8_busy_end", busy, 1'b0);

    check("onehot_events", n_multi, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/btn_gesture_ctrl.md
Name: btn_gesture_ctrl

Overview:
- Controller that sits downstream of the switch debouncer.
- Consumes the debounced level and rise tick and classifies each press as short, long or double-click.
- Emits one-cycle event pulses to application logic.
- Time base is an internal millisecond prescaler derived from ClkFreq, so the debouncer and this controller share one timing convention.

Parameters:
- ClkFreq, 100_000_000, clock frequency in Hz; must be a multiple of 1000.
- LongPressMs, 1000, hold time in ms that classifies a press as long.
- DoubleGapMs, 250, maximum release-to-press gap in ms for a double-click.
- RepeatMs, 100, auto-repeat period in ms (used only with the optional feature).

Ports:
- clk_i  input  1  system clock.
- rst_ni  input  1  asynchronous active-low reset.
- enable_i  input  1  controller enable; low forces IDLE.
- db_level_i  input  1  debounced switch level.
- db_tick_i  input  1  one-cycle pulse on debounced rising edge.
- short_o  output  1  one-cycle pulse: short press recognised.
- long_o  output  1  one-cycle pulse: long press recognised.
- double_o  output  1  one-cycle pulse: double-click recognised.
- repeat_o  output  1  one-cycle auto-repeat pulse; tied 0 without BTN_REPEAT_EN.
- busy_o  output  1  high whenever state != IDLE.

Behaviour:
- Single clock domain. Reset is asynchronous and active-low; deassertion is synchronous to clk_i.
- Reset state: FSM = IDLE; prescaler and ms counter = 0; level_q = 0; all outputs = 0.
- Fall detect: fall = level_q && !db_level_i, where level_q is db_level_i registered. Rise is db_tick_i only.
- Time base: the prescaler counts 0..ClkFreq/1000-1 and produces ms_tick on wrap. ms_cnt increments on ms_tick and saturates at max(LongPressMs, DoubleGapMs, RepeatMs).
- Counter widths: $clog2 of the maximum value + 1.
- Prescaler and ms_cnt are both cleared on every state transition.
- States and transitions:
  - IDLE: db_tick_i -> PRESS1.
  - PRESS1: fall -> GAP. Otherwise, ms_cnt == LongPressMs -> pulse long_o, go to HOLD. If both occur in the same cycle, fall wins.
  - GAP: db_tick_i -> PRESS2. Otherwise, ms_cnt == DoubleGapMs -> pulse short_o, go to IDLE. If both occur in the same cycle, tick wins (no short_o).
  - PRESS2: fall -> pulse double_o, go to IDLE. Press duration is irrelevant; no long_o is issued from PRESS2.
  - HOLD: fall -> IDLE, no pulse.
- Outputs are registered: each pulse is high exactly one cycle, in the cycle after the triggering condition is sampled.
- At most one event output is high in any cycle.
- enable_i low: synchronously forces IDLE, clears counters, suppresses all pulses. Takes priority over every transition.
- db_tick_i while in PRESS1, PRESS2 or HOLD is ignored.
- Reset asserted mid-gesture aborts the gesture; no event is issued for it after release.

Optional Feature:
- BTN_REPEAT_EN defined:
  - In HOLD, ms_cnt restarts on reaching RepeatMs.
  - A repeat_o pulse is issued each RepeatMs, the first one RepeatMs after long_o.
  - Repeats stop on fall.
- BTN_REPEAT_EN undefined: repeat_o tied to 0 and no repeat logic is synthesised.

Decomposition:
- btn_ctrl_pkg holds:
  - state enum: IDLE, PRESS1, GAP, PRESS2, HOLD.
  - typedef of the event vector {short, long, double, repeat}.
  - function computing CyclesPerMs from ClkFreq.
- Sub-module ms_timer (prescaler + saturating ms counter):
  - Inputs: clear_i.
  - Outputs: ms_tick_o, ms_cnt_o.
  - Parameters: ClkFreq, MaxMs.

Test Plan:
- Common setup for all cases: ClkFreq=10_000 (10 clk/ms), LongPressMs=20, DoubleGapMs=5, RepeatMs=10.
- Press, hold 8 ms, release, idle -> exactly one short_o pulse ~50 cycles after the fall; long_o and double_o stay 0; busy_o then 0.
- Press, hold 25 ms -> long_o pulse ~200 cycles after db_tick_i; release -> no further pulses.
- Press 3 ms, release, re-press after 2 ms, release after 3 ms -> one double_o pulse one cycle after the second fall; short_o never high.
- Press 3 ms, release; during GAP drive rst_ni low for 2 cycles -> outputs 0 immediately and FSM IDLE; no short_o afterwards.
- Press 3 ms, release; during GAP drive enable_i low for 1 cycle -> no short_o; busy_o 0 the next cycle.
- With BTN_REPEAT_EN, hold 45 ms -> long_o at 20 ms; repeat_o at 30 ms and 40 ms; none after release.
